// File: rtl/audio_pdm_output_pkg.sv
// Shared definitions for the PDM audio output stage: pipeline state
// encoding, sample range helpers, gain constant and dither LFSR constants.
package audio_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCALE  = 2'd1,
        S_CLAMP  = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

    localparam int SAMPLE_BITS_DEF = 12;
    localparam int VOLUME_BITS_DEF = 8;

    // Offset added to a signed sample to obtain its offset-binary level.
    function automatic int midscale(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int sample_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sample_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

    function automatic int unity_gain(input int vbits);
        return 1 << (vbits - 1);
    endfunction

    localparam int MIDSCALE   = midscale(SAMPLE_BITS_DEF);
    localparam int UNITY_GAIN = unity_gain(VOLUME_BITS_DEF);

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/audio_pdm_output_sigma_delta_mod.sv
// First-order sigma-delta modulator: free-running accumulator whose carry
// is the PDM bit. Optional triangular-ish dither via AUDIO_PDM_DITHER_EN.
module sigma_delta_mod
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [SAMPLE_BITS-1:0] level,
    output logic                   pdm_out
);

    logic [SAMPLE_BITS-1:0] acc_q;
    logic                   pdm_q;
    logic [SAMPLE_BITS-1:0] mod_in;
    logic [SAMPLE_BITS:0]   sum;

`ifdef AUDIO_PDM_DITHER_EN
    logic [15:0]                   lfsr_q;
    logic                          lfsr_fb;
    logic signed [SAMPLE_BITS+1:0] dith_sum;

    assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

    // LFSR advances every clock from a fixed seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end

    // Add dither in -2..+1 and saturate the modulator input to its range.
    always_comb begin
        dith_sum = $signed({2'b00, level})
                 + $signed({{SAMPLE_BITS{lfsr_q[1]}}, lfsr_q[1:0]});
        mod_in   = dith_sum[SAMPLE_BITS-1:0];
        if (dith_sum[SAMPLE_BITS+1])   mod_in = '0;
        else if (dith_sum[SAMPLE_BITS]) mod_in = '1;
    end
`else
    assign mod_in = level;
`endif

    // Accumulate level; the carry out is the density-modulated bit.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, mod_in};
    end

    // Accumulator wraps naturally; output bit is registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= sum[SAMPLE_BITS-1:0];
            pdm_q <= sum[SAMPLE_BITS];
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/audio_pdm_output.sv
// Audio output stage: per sample applies volume, saturates, mutes and
// converts to offset-binary, then drives a sigma-delta PDM modulator.
// Optional dither in the modulator: define AUDIO_PDM_DITHER_EN.
module audio_pdm_output
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 12,
    parameter int VOLUME_BITS = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sample_clk,
    input  logic [SAMPLE_BITS-1:0] in,
    input  logic [VOLUME_BITS-1:0] volume,
    input  logic                   mute,
    output logic                   pdm_out,
    output logic                   sample_taken,
    output logic                   clip
);

    localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam logic [SAMPLE_BITS-1:0] MID_L =
        SAMPLE_BITS'(midscale(SAMPLE_BITS));
    localparam logic signed [PROD_BITS-1:0] MAX_P =
        PROD_BITS'(sample_max(SAMPLE_BITS));
    localparam logic signed [PROD_BITS-1:0] MIN_P =
        PROD_BITS'(sample_min(SAMPLE_BITS));
    localparam logic signed [SAMPLE_BITS-1:0] MAX_S =
        SAMPLE_BITS'(sample_max(SAMPLE_BITS));
    localparam logic signed [SAMPLE_BITS-1:0] MIN_S =
        SAMPLE_BITS'(sample_min(SAMPLE_BITS));

    state_e                        state_q, state_d;
    logic                          prev_sclk_q;
    logic                          edge_w;
    logic signed [SAMPLE_BITS-1:0] in_reg_q;
    logic signed [PROD_BITS-1:0]   prod_q;
    logic signed [PROD_BITS-1:0]   scaled_w;
    logic signed [SAMPLE_BITS-1:0] sat_w, sat_q;
    logic                          clip_w;
    logic [SAMPLE_BITS-1:0]        level_q;
    logic                          sample_taken_q;
    logic                          clip_q;

    assign edge_w = sample_clk & ~prev_sclk_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Fixed 3-step pipeline; a new edge in any state restarts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_SCALE:  state_d = S_CLAMP;
            S_CLAMP:  state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (edge_w) state_d = S_SCALE;
    end

    // Rescale to sample units and saturate to the signed sample range.
    always_comb begin
        scaled_w = prod_q >>> (VOLUME_BITS - 1);
        sat_w    = scaled_w[SAMPLE_BITS-1:0];
        clip_w   = 1'b0;
        if (scaled_w > MAX_P) begin
            sat_w  = MAX_S;
            clip_w = 1'b1;
        end else if (scaled_w < MIN_P) begin
            sat_w  = MIN_S;
            clip_w = 1'b1;
        end
    end

    // Sample pipeline; stage work is skipped when an edge discards it,
    // so a superseded sample can neither pulse clip nor reach level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_sclk_q    <= 1'b0;
            in_reg_q       <= '0;
            prod_q         <= '0;
            sat_q          <= '0;
            level_q        <= MID_L;
            sample_taken_q <= 1'b0;
            clip_q         <= 1'b0;
        end else begin
            prev_sclk_q    <= sample_clk;
            sample_taken_q <= edge_w;
            clip_q         <= 1'b0;
            if (edge_w) begin
                in_reg_q <= in;
            end else begin
                case (state_q)
                    S_SCALE: prod_q <= PROD_BITS'(in_reg_q)
                                     * PROD_BITS'($signed({1'b0, volume}));
                    S_CLAMP: begin
                        sat_q  <= sat_w;
                        clip_q <= clip_w;
                    end
                    S_COMMIT: level_q <= mute ? MID_L : unsigned'(sat_q) + MID_L;
                    default: ;
                endcase
            end
        end
    end

    assign sample_taken = sample_taken_q;
    assign clip         = clip_q;

    sigma_delta_mod #(
        .SAMPLE_BITS(SAMPLE_BITS)
    ) u_mod (
        .clk    (clk),
        .resetn (resetn),
        .level  (level_q),
        .pdm_out(pdm_out)
    );

endmodule

// File: tb/tb_audio_pdm_output.sv
// Self-checking bench for audio_pdm_output: vector table of samples with
// hand-derived levels, scoreboard of expected commits, PDM density counts,
// restart and mid-pipeline reset sequences.
module tb_audio_pdm_output;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_clk = 1'b0;
    logic [11:0] in = '0;
    logic [7:0]  volume = '0;
    logic        mute = 1'b0;
    logic        pdm_out, sample_taken, clip;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [11:0] in;
        logic [7:0]  vol;
        logic        mute;
        int          exp_level;
        logic        exp_clip;
        bit          cnt;
    } vec_t;

    typedef struct {
        int   level;
        logic clip;
    } exp_t;

    vec_t vecs[11];
    exp_t sb_q[$];

    audio_pdm_output #(
        .SAMPLE_BITS(12),
        .VOLUME_BITS(8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sample_clk  (sample_clk),
        .in          (in),
        .volume      (volume),
        .mute        (mute),
        .pdm_out     (pdm_out),
        .sample_taken(sample_taken),
        .clip        (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_near(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act >= exp - tol && act <= exp + tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    endtask

    task automatic count_ones(input int n, output int ones, output int stray);
        ones  = 0;
        stray = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ones  += int'(pdm_out);
            stray += int'(sample_taken | clip);
        end
    endtask

    // Exact density without dither; small deviation allowed with it.
    task automatic chk_ones(input string name, input int act, input int exp_lvl);
`ifdef AUDIO_PDM_DITHER_EN
        chk_near(name, act, exp_lvl, 16);
`else
        chk(name, act, exp_lvl);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e, got;
        int   ones, stray;
        @(negedge clk);
        in = v.in; volume = v.vol; mute = v.mute; sample_clk = 1'b1;
        e.level = v.exp_level;
        e.clip  = v.exp_clip;
        sb_q.push_back(e);
        @(negedge clk);
        chk("taken_T1", int'(sample_taken), 1);
        chk("clip_T1", int'(clip), 0);
        sample_clk = 1'b0;
        @(negedge clk);
        chk("taken_T2", int'(sample_taken), 0);
        chk("clip_T2", int'(clip), 0);
        @(negedge clk);
        got = sb_q.pop_front();
        chk("clip_T3", int'(clip), int'(got.clip));
        @(negedge clk);
        chk("level_T4", int'(dut.level_q), got.level);
        chk("clip_T4", int'(clip), 0);
        if (v.cnt) begin
            count_ones(4096, ones, stray);
            chk_ones("ones_4096", ones, got.level);
            chk("stray_pulses", stray, 0);
        end
    endtask

    initial begin
        int   ones, stray;
        exp_t e, got;

        //           in       vol    mute  level clip  count
        vecs[0]  = '{12'h7FF, 8'h80, 1'b0, 4095, 1'b0, 1'b1};
        vecs[1]  = '{12'h600, 8'hFF, 1'b0, 4095, 1'b1, 1'b0};
        vecs[2]  = '{12'h800, 8'h40, 1'b0, 1024, 1'b0, 1'b1};
        vecs[3]  = '{12'h7FF, 8'h80, 1'b1, 2048, 1'b0, 1'b0};
        vecs[4]  = '{12'h800, 8'hFF, 1'b0, 0,    1'b1, 1'b1};
        vecs[5]  = '{12'h000, 8'hFF, 1'b0, 2048, 1'b0, 1'b0};
        vecs[6]  = '{12'hFFF, 8'h80, 1'b0, 2047, 1'b0, 1'b0};
        vecs[7]  = '{12'hFFF, 8'h01, 1'b0, 2047, 1'b0, 1'b0};
        vecs[8]  = '{12'h123, 8'h80, 1'b0, 2339, 1'b0, 1'b0};
        vecs[9]  = '{12'h400, 8'hFF, 1'b0, 4088, 1'b0, 1'b0};
        vecs[10] = '{12'h7FF, 8'h00, 1'b0, 2048, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pdm", int'(pdm_out), 0);
        chk("rst_taken", int'(sample_taken), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_level", int'(dut.level_q), MIDSCALE);
        chk("rst_state", int'(dut.state_q), int'(S_IDLE));
        resetn = 1'b1;

        // Idle midscale density
        count_ones(4096, ones, stray);
        chk_ones("idle_ones", ones, 2048);
        chk("idle_stray", stray, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Restart: 0x100 is superseded by 0x200 two cycles later
        volume = 8'(UNITY_GAIN);
        mute   = 1'b0;
        @(negedge clk);
        in = 12'h100; sample_clk = 1'b1;
        @(negedge clk);
        chk("rs_taken1", int'(sample_taken), 1);
        sample_clk = 1'b0;
        @(negedge clk);
        in = 12'h200; sample_clk = 1'b1;
        e.level = 2560; e.clip = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        chk("rs_taken2", int'(sample_taken), 1);
        sample_clk = 1'b0;
        @(negedge clk);
        chk("rs_no_commit", int'(dut.level_q), 2048);
        chk("rs_clip_a", int'(clip), 0);
        @(negedge clk);
        got = sb_q.pop_front();
        chk("rs_clip_b", int'(clip), int'(got.clip));
        chk("rs_hold", int'(dut.level_q), 2048);
        @(negedge clk);
        chk("rs_level", int'(dut.level_q), got.level);

        // Reset during SCALE aborts the pipeline
        @(negedge clk);
        in = 12'h7FF; sample_clk = 1'b1;
        @(negedge clk);
        resetn = 1'b0; sample_clk = 1'b0;
        #1;
        chk("ar_level", int'(dut.level_q), 2048);
        chk("ar_state", int'(dut.state_q), int'(S_IDLE));
        chk("ar_taken", int'(sample_taken), 0);
        @(negedge clk);
        resetn = 1'b1;
        count_ones(6, ones, stray);
        chk("ar_stray", stray, 0);
        chk("ar_level_hold", int'(dut.level_q), 2048);

`ifdef AUDIO_PDM_DITHER_EN
        run_vec(vecs[2]);
        count_ones(65536, ones, stray);
        chk_near("dith_ones_64k", ones, 1024 * 16, 64);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_pdm_output.md
Name: audio_pdm_output

Overview:
- Output stage directly downstream of the state-variable filter. Consumes one filtered signed sample per sample_clk period.
- Per sample: applies a master-volume gain, saturates, applies mute, and converts to offset-binary.
- Drives a first-order sigma-delta modulator at full clk rate, producing a 1-bit PDM stream for an external RC low-pass / audio pin.
- One multiply per sample; the core is a small sequential pipeline plus a free-running accumulator.

Parameters:
- SAMPLE_BITS, 12, width of input sample and of the modulator level.
- VOLUME_BITS, 8, width of unsigned volume. Unity gain = 2^(VOLUME_BITS-1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetn  input  1  asynchronous, active-low reset.
- sample_clk  input  1  sample-rate strobe, synchronous to clk; each rising edge starts one sample.
- in  input  SAMPLE_BITS  signed filtered sample, captured on the sample_clk rising edge.
- volume  input  VOLUME_BITS  unsigned gain; gain = volume / 2^(VOLUME_BITS-1), so 0x80 = 1.0 and 0xFF ≈ 1.99.
- mute  input  1  forces midscale output, sampled in COMMIT.
- pdm_out  output  1  PDM bitstream.
- sample_taken  output  1  one-cycle pulse: input sample captured.
- clip  output  1  one-cycle pulse: scaled sample saturated.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pdm_out=0, sample_taken=0, clip=0, acc=0, level=2^(SAMPLE_BITS-1) (midscale), prev_sample_clk=0.
- Edge detect: a rising edge is seen in cycle T when prev_sample_clk=0 and sample_clk=1. prev_sample_clk updates every clk.
- States: IDLE -> SCALE -> CLAMP -> COMMIT -> IDLE, one clk each.
  - Edge in T: in_reg<=in, state<=SCALE, sample_taken=1 during T+1.
  - SCALE (T+1): prod <= in_reg * signed({1'b0,volume}); prod is SAMPLE_BITS+VOLUME_BITS+1 bits, signed.
  - CLAMP (T+2): scaled = prod >>> (VOLUME_BITS-1), arithmetic shift. Saturate to MIN=-2^(SAMPLE_BITS-1), MAX=2^(SAMPLE_BITS-1)-1. clip=1 during T+3 if saturation occurred.
  - COMMIT (T+3): level <= mute ? 2^(SAMPLE_BITS-1) : sat + 2^(SAMPLE_BITS-1), unsigned. The new level is visible to the modulator from T+4.
- Edge while not IDLE: the pipeline restarts with the new sample and the in-flight sample is discarded. The minimum useful sample period is 4 clks.
- Modulator, every clk regardless of state: sum = {1'b0,acc[SAMPLE_BITS-1:0]} + level; acc<=sum; pdm_out<=sum[SAMPLE_BITS]. Ones density = level / 2^SAMPLE_BITS. level=0 gives constant 0. The accumulator wraps naturally.
- level holds between samples. A volume or mute change affects only the next committed sample.
- Reset mid-operation aborts the pipeline. No partial level is ever committed.

Optional Feature:
- Macro: AUDIO_PDM_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 on reset, advances every clk.
  - Modulator input = level + sign-extended lfsr[1:0] (range -2..+1), saturated to [0, 2^SAMPLE_BITS-1].
- Undefined:
  - No LFSR logic.
  - Modulator uses level directly, making output exactly periodic for constant level.

Decomposition:
- Shared package audio_pkg:
  - state encoding (IDLE/SCALE/CLAMP/COMMIT)
  - MIDSCALE
  - sample MIN/MAX helpers
  - UNITY_GAIN
  - LFSR seed and tap constants
- One natural sub-module: sigma_delta_mod.
  - Contents: accumulator, pdm_out register, optional dither.
  - Ports: clk, resetn, level, pdm_out.

Test Plan (dither disabled unless stated):
- Reset, no sample_clk edges, 4096 clks -> exactly 2048 ones on pdm_out. sample_taken and clip never assert.
- in=0x7FF, volume=0x80, edge at T -> sample_taken at T+1, clip=0, level=4095 at T+3. Over the next 4096 clks, 4095 ones.
- in=0x600, volume=0xFF -> 1536*255>>7=3060, saturates to 2047, clip pulse at T+3, level=4095.
- in=0x800 (-2048), volume=0x40 -> -1024, level=1024, 1024 ones per 4096 clks. Then mute=1 with in=0x7FF -> level=2048.
- in=0x100 edge at T, in=0x200 edge at T+2 -> first sample discarded, level=2048+512=2560 at T+5. resetn pulsed at T+1 of a new sample -> level=2048, state IDLE.
- AUDIO_PDM_DITHER_EN: level=0 -> modulator input never below 0. level=4095 -> never above 4095. Ones count over 65536 clks within ±64 of level*16.
